// File: rtl/seq_fill_engine_if.sv
// Control, seed and read-port bundle for seq_fill_engine.
// The master side requests fills and reads; the slave side is the engine.
interface seq_fill_engine_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 6
);

  logic              start;
  logic [1:0]        mode;
  logic [DATA_W-1:0] seed0;
  logic [DATA_W-1:0] seed1;
  logic              busy;
  logic              done;
  logic              overflow;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  modport master (
    output start, mode, seed0, seed1, rd_en, rd_addr,
    input  busy, done, overflow, rd_data, rd_valid
  );

  modport slave (
    input  start, mode, seed0, seed1, rd_en, rd_addr,
    output busy, done, overflow, rd_data, rd_valid
  );

endinterface

// File: rtl/seq_fill_engine.sv
// Recurrence fill engine: writes seed0, seed1, then op(e[j-2], e[j-1]) into a
// DEPTH-entry register file, one entry per cycle, then serves 1-cycle reads.
module seq_fill_engine #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input logic             clk,
  input logic             rst_n,
  seq_fill_engine_if.slave bus
);

  localparam int unsigned      IDX_W    = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_XOR = 2'b10;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]        state_q,    state_d;
  logic [IDX_W-1:0]  widx_q,     widx_d;
  logic [DATA_W-1:0] a_q,        a_d;
  logic [DATA_W-1:0] b_q,        b_d;
  logic [1:0]        mode_q,     mode_d;
  logic              ovf_q,      ovf_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q,  rd_data_d;

  logic              accept_c;
  logic              in_range_c;
  logic              we_c;
  logic [DATA_W-1:0] wdata_c;
  logic [DATA_W:0]   sum_c;
  logic [DATA_W:0]   diff_c;
  logic [DATA_W-1:0] alu_c;
  logic              alu_flag_c;

  // Extra top bit of sum/diff is the carry-out / borrow.
  always_comb begin
    sum_c      = {1'b0, a_q} + {1'b0, b_q};
    diff_c     = {1'b0, a_q} - {1'b0, b_q};
    alu_c      = sum_c[DATA_W-1:0];
    alu_flag_c = sum_c[DATA_W];
    case (mode_q)
      MODE_SUB: begin
        alu_c      = diff_c[DATA_W-1:0];
        alu_flag_c = diff_c[DATA_W];
      end
      MODE_XOR: begin
        alu_c      = a_q ^ b_q;
        alu_flag_c = 1'b0;
      end
      default: ;
    endcase
  end

  assign accept_c   = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign in_range_c = ({1'b0, bus.rd_addr} < (ADDR_W + 1)'(DEPTH));

  // Next-state and datapath control; an accepted start overrides everything.
  always_comb begin
    state_d    = state_q;
    widx_d     = widx_q;
    a_d        = a_q;
    b_d        = b_q;
    mode_d     = mode_q;
    ovf_d      = ovf_q;
    busy_d     = busy_q;
    done_d     = done_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    we_c       = 1'b0;
    wdata_c    = a_q;

    case (state_q)
      ST_IDLE: ;
      ST_FILL: begin
        we_c = 1'b1;
        if (widx_q == '0) begin
          wdata_c = a_q;
        end else if (widx_q == IDX_W'(1)) begin
          wdata_c = b_q;
        end else begin
          wdata_c = alu_c;
          a_d     = b_q;
          b_d     = alu_c;
          ovf_d   = ovf_q | alu_flag_c;
        end
        if (widx_q == LAST_IDX) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          widx_d = widx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (bus.rd_en) begin
          rd_valid_d = 1'b1;
          rd_data_d  = in_range_c ? mem[IDX_W'(bus.rd_addr)] : '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept_c) begin
      state_d    = ST_FILL;
      widx_d     = '0;
      a_d        = bus.seed0;
      b_d        = bus.seed1;
      mode_d     = bus.mode;
      ovf_d      = 1'b0;
      busy_d     = 1'b1;
      done_d     = 1'b0;
      rd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      widx_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      mode_q     <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      widx_q     <= widx_d;
      a_q        <= a_d;
      b_q        <= b_d;
      mode_q     <= mode_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Storage is deliberately not reset; it is unreadable until a fill completes.
  always_ff @(posedge clk) begin
    if (we_c) begin
      mem[widx_q] <= wdata_c;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;

endmodule

// File: tb/tb_seq_fill_engine.sv
// Bench for seq_fill_engine: three instances (DEPTH 8, 16, 6) driven with directed
// fills; read expectations are queued and checked by a separate monitor.
module tb_seq_fill_engine;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  logic [2:0]       start_v, rd_en_v;
  logic [2:0][1:0]  mode_v;
  logic [2:0][7:0]  s0_v, s1_v;
  logic [2:0][3:0]  addr_v;
  logic [2:0]       busy_v, done_v, ovf_v, rv_v;
  logic [2:0][7:0]  rdata_v;

  logic [7:0] exp_q [3][$];

  seq_fill_engine_if #(.DATA_W(8), .ADDR_W(3)) if_a ();
  seq_fill_engine_if #(.DATA_W(8), .ADDR_W(4)) if_b ();
  seq_fill_engine_if #(.DATA_W(8), .ADDR_W(3)) if_c ();

  seq_fill_engine #(.DATA_W(8), .DEPTH(8),  .ADDR_W(3)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  seq_fill_engine #(.DATA_W(8), .DEPTH(16), .ADDR_W(4)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  seq_fill_engine #(.DATA_W(8), .DEPTH(6),  .ADDR_W(3)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  assign if_a.start = start_v[0];  assign if_b.start = start_v[1];  assign if_c.start = start_v[2];
  assign if_a.mode  = mode_v[0];   assign if_b.mode  = mode_v[1];   assign if_c.mode  = mode_v[2];
  assign if_a.seed0 = s0_v[0];     assign if_b.seed0 = s0_v[1];     assign if_c.seed0 = s0_v[2];
  assign if_a.seed1 = s1_v[0];     assign if_b.seed1 = s1_v[1];     assign if_c.seed1 = s1_v[2];
  assign if_a.rd_en = rd_en_v[0];  assign if_b.rd_en = rd_en_v[1];  assign if_c.rd_en = rd_en_v[2];
  assign if_a.rd_addr = addr_v[0][2:0];
  assign if_b.rd_addr = addr_v[1];
  assign if_c.rd_addr = addr_v[2][2:0];

  assign busy_v  = {if_c.busy, if_b.busy, if_a.busy};
  assign done_v  = {if_c.done, if_b.done, if_a.done};
  assign ovf_v   = {if_c.overflow, if_b.overflow, if_a.overflow};
  assign rv_v    = {if_c.rd_valid, if_b.rd_valid, if_a.rd_valid};
  assign rdata_v = {if_c.rd_data, if_b.rd_data, if_a.rd_data};

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every rd_valid pulse must match the oldest queued value.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rv_v[i] === 1'b1) begin
        vectors++;
        if (exp_q[i].size() == 0) begin
          miscompares++;
          $display("FAIL rd_unexpected[%0d]: got rd_valid=1 data=%0d expected no read", i, rdata_v[i]);
        end else begin
          logic [7:0] e;
          e = exp_q[i].pop_front();
          if (rdata_v[i] !== e) begin
            miscompares++;
            $display("FAIL rd_data[%0d]: got %0d expected %0d", i, rdata_v[i], e);
          end
        end
      end
    end
  end

  // Issue a start at a negedge; returns at the negedge after the accepting edge.
  task automatic start_fill(input int i, input logic [1:0] m, input logic [7:0] a, input logic [7:0] b);
    start_v[i] = 1'b1; mode_v[i] = m; s0_v[i] = a; s1_v[i] = b;
    @(negedge clk);
    start_v[i] = 1'b0;
    check("start_busy", busy_v[i], 1);
    check("start_done_clr", done_v[i], 0);
    check("start_ovf_clr", ovf_v[i], 0);
  endtask

  // Counts remaining busy cycles until done rises, bounded.
  task automatic wait_done(input int i, input int unsigned exp_cycles);
    int unsigned cnt = 0;
    int unsigned guard = 0;
    while (done_v[i] !== 1'b1 && guard < 200) begin
      if (busy_v[i] === 1'b1) cnt++;
      guard++;
      @(negedge clk);
    end
    check("busy_cycles", cnt, exp_cycles);
    check("done_high", done_v[i], 1);
    check("busy_low_at_done", busy_v[i], 0);
  endtask

  task automatic rd(input int i, input logic [3:0] addr, input logic [7:0] exp);
    rd_en_v[i] = 1'b1; addr_v[i] = addr;
    exp_q[i].push_back(exp);
    @(negedge clk);
  endtask

  task automatic read_seq(input int i, input int n, input logic [7:0] tbl [16]);
    for (int k = 0; k < n; k++) rd(i, 4'(k), tbl[k]);
    rd_en_v[i] = 1'b0;
  endtask

  logic [7:0] fib01 [16] = '{0,1,1,2,3,5,8,13, 0,0,0,0,0,0,0,0};
  logic [7:0] fib11 [16] = '{1,1,2,3,5,8,13,21,34,55,89,144,233,121,98,219};
  logic [7:0] sub_t [16] = '{10,3,7,252,11,241,26,215, 0,0,0,0,0,0,0,0};
  logic [7:0] xor_t [16] = '{5,3,6,5,3,6,5,3, 0,0,0,0,0,0,0,0};
  logic [7:0] c_add [16] = '{2,3,5,8,13,21, 0,0,0,0,0,0,0,0,0,0};
  logic [7:0] c_sub [16] = '{9,4,5,255,6,249, 0,0,0,0,0,0,0,0,0,0};

  initial begin
    start_v = '0; rd_en_v = '0; mode_v = '0; s0_v = '0; s1_v = '0; addr_v = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy_v[0], 0);
    check("rst_done", done_v[0], 0);
    check("rst_ovf", ovf_v[0], 0);
    check("rst_rd_valid", rv_v[0], 0);
    check("rst_rd_data", rdata_v[0], 0);
    rst_n = 1'b1;
    @(negedge clk);

    // A: add 0,1 with a stray start (and junk seeds) in the third fill cycle
    start_fill(0, 2'b00, 8'd0, 8'd1);
    @(negedge clk); @(negedge clk);
    start_v[0] = 1'b1; mode_v[0] = 2'b10; s0_v[0] = 8'd99; s1_v[0] = 8'd77;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_done(0, 5);
    check("a_add_ovf", ovf_v[0], 0);
    read_seq(0, 8, fib01);

    // A: sub 10,3 borrows
    start_fill(0, 2'b01, 8'd10, 8'd3);
    wait_done(0, 8);
    check("a_sub_ovf", ovf_v[0], 1);
    read_seq(0, 8, sub_t);

    // A: xor 5,3; a read during fill is ignored and rd_data holds
    start_fill(0, 2'b10, 8'd5, 8'd3);
    rd_en_v[0] = 1'b1; addr_v[0] = 4'd0;
    @(negedge clk);
    rd_en_v[0] = 1'b0;
    check("fill_rd_valid", rv_v[0], 0);
    check("fill_rd_hold", rdata_v[0], 215);
    wait_done(0, 7);
    check("a_xor_ovf", ovf_v[0], 0);
    read_seq(0, 8, xor_t);

    // B: 16-deep add 1,1 wraps modulo 256
    start_fill(1, 2'b00, 8'd1, 8'd1);
    wait_done(1, 16);
    check("b_add_ovf", ovf_v[1], 1);
    read_seq(1, 16, fib11);

    // B: reserved mode behaves as add
    start_fill(1, 2'b11, 8'd0, 8'd1);
    wait_done(1, 16);
    check("b_rsv_ovf", ovf_v[1], 1);
    rd(1, 4'd12, 8'd144); rd(1, 4'd13, 8'd233); rd(1, 4'd14, 8'd121); rd(1, 4'd15, 8'd98);
    rd_en_v[1] = 1'b0;

    // C: 6-deep; out-of-range reads return 0 with rd_valid
    start_fill(2, 2'b00, 8'd2, 8'd3);
    wait_done(2, 6);
    check("c_add_ovf", ovf_v[2], 0);
    rd(2, 4'd0, 8'd2); rd(2, 4'd7, 8'd0); rd(2, 4'd5, 8'd21); rd(2, 4'd6, 8'd0);
    read_seq(2, 6, c_add);

    // C: start and rd_en together in DONE -> read dropped, fill begins
    start_v[2] = 1'b1; mode_v[2] = 2'b10; s0_v[2] = 8'd4; s1_v[2] = 8'd4;
    rd_en_v[2] = 1'b1; addr_v[2] = 4'd1;
    @(negedge clk);
    start_v[2] = 1'b0; rd_en_v[2] = 1'b0;
    check("start_rd_drop_valid", rv_v[2], 0);
    check("start_rd_busy", busy_v[2], 1);
    check("start_rd_done", done_v[2], 0);
    wait_done(2, 6);
    check("c_xor_ovf", ovf_v[2], 0);

    // C: back-to-back start in the first DONE cycle
    start_fill(2, 2'b01, 8'd9, 8'd4);
    wait_done(2, 6);
    check("c_sub_ovf", ovf_v[2], 1);
    read_seq(2, 6, c_sub);

    // A: reset mid-fill after overflow has already been set
    start_fill(0, 2'b00, 8'd200, 8'd100);
    repeat (3) @(negedge clk);
    check("pre_rst_ovf", ovf_v[0], 1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy_v[0], 0);
    check("midrst_done", done_v[0], 0);
    check("midrst_ovf", ovf_v[0], 0);
    check("midrst_rd_valid", rv_v[0], 0);
    check("midrst_rd_data", rdata_v[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd_en_v[0] = 1'b1; addr_v[0] = 4'd2;
    @(negedge clk);
    rd_en_v[0] = 1'b0;
    check("idle_rd_valid", rv_v[0], 0);
    start_fill(0, 2'b00, 8'd0, 8'd1);
    wait_done(0, 8);
    check("refill_ovf", ovf_v[0], 0);
    read_seq(0, 8, fib01);

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) check("queue_drained", exp_q[i].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_fill_engine.md
# seq_fill_engine

Parametrised recurrence engine. It fills an internal DEPTH-entry register file with a two-term sequence: two seed values, then each later entry is computed from the previous two with a selectable ALU operation. After the fill it serves single-port, one-cycle-latency reads. It supersedes the fixed 64-entry, add-only Fibonacci fill block: width, depth and operation are now configurable, start/busy/done handshake is explicit, and overflow is flagged.

## Interface
- DATA_W, 32, width of each entry and of the seeds
- DEPTH, 64, number of entries; must be ≥ 3
- ADDR_W, $clog2(DEPTH), read address width
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request a new fill; sampled on rising clk
- mode  in  2  operation: 00 add, 01 sub (a−b), 10 xor, 11 reserved (treated as add)
- seed0  in  DATA_W  value for entry 0
- seed1  in  DATA_W  value for entry 1
- busy  out  1  fill in progress
- done  out  1  fill complete, read port live
- overflow  out  1  sticky: carry (add) or borrow (sub) occurred during the last fill
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  read address
- rd_data  out  DATA_W  read result
- rd_valid  out  1  rd_data valid this cycle (1-cycle pulse)

## Operation
- States:
  - IDLE: after reset.
  - FILL: writes one entry per cycle.
  - DONE: read port active.
- IDLE/DONE + start=1 at an edge → FILL.
  - At that edge, capture seed0, seed1 and mode into internal registers.
  - Clear done and overflow; set busy; set the write index to 0.
- In FILL, one write per cycle at index j:
  - j=0 writes seed0; j=1 writes seed1.
  - j≥2 writes op(a,b), where a = entry j−2 and b = entry j−1.
  - a and b are held in pipeline registers, not re-read from memory.
- Arithmetic is modulo 2^DATA_W.
  - add: a+b. overflow is set if the carry-out is 1.
  - sub: a−b. overflow is set if a<b.
  - xor: never sets overflow.
  - overflow is sticky until the next accepted start.
- Write of index DEPTH−1 → DONE: busy=0, done=1.
- start during FILL is ignored; seeds, mode and progress are unaffected.
- Reads:
  - Honoured only in DONE.
  - rd_en=1 at an edge in DONE → at the next edge rd_valid=1 and rd_data=mem[rd_addr].
  - rd_addr ≥ DEPTH returns 0, still with rd_valid=1.
  - rd_en outside DONE → rd_valid=0 and rd_data holds its previous value.
- start and rd_en in the same DONE cycle: start wins. The read is dropped (rd_valid=0 next cycle).
- rst_n low at any time, including mid-fill:
  - Immediate return to IDLE; busy=0, done=0, overflow=0, rd_valid=0, rd_data=0.
  - Memory contents are not cleared. They are unreadable until the next completed fill.

## Timing
- Reset values: busy=0, done=0, overflow=0, rd_valid=0, rd_data=0.
- start accepted at edge k. busy is high from after edge k.
- Entry j is written at edge k+1+j.
- At edge k+DEPTH: busy falls and done rises, in the same edge.
- busy is high for exactly DEPTH cycles. done is never high while busy is high.
- Back-to-back fills: start may be high in the first DONE cycle and is accepted then.
- Read latency is 1 cycle. Reads are fully pipelined, one per cycle.
- overflow is valid when done=1. It may update during FILL.

## Test plan
- DATA_W=8, DEPTH=8, mode=00, seeds 0,1, start at edge k:
  - Reads of 0..7 return 0,1,1,2,3,5,8,13.
  - done=1 after edge k+8; busy high for exactly 8 cycles; overflow=0.
- DATA_W=8, DEPTH=16, mode=00, seeds 1,1:
  - entry11=144, entry12=233, entry13=121, entry14=98, entry15=219.
  - overflow=1.
- DATA_W=8, DEPTH=8, mode=01, seeds 10,3:
  - entry2=7, entry3=252.
  - overflow=1.
- DATA_W=8, DEPTH=8, mode=10, seeds 5,3 → entries 5,3,6,5,3,6,5,3; overflow=0.
- Handshake and reset:
  - start pulsed at cycle 3 of a fill → no restart; done is still at k+DEPTH.
  - rd_en during FILL → rd_valid stays 0.
  - rst_n low mid-fill → busy=0, done=0 immediately; a new start completes a correct fill.
- Read boundaries (DEPTH=6, ADDR_W=3):
  - rd_addr=7 → rd_data=0 with rd_valid=1.
  - Consecutive reads on successive cycles return matching data with 1-cycle lag.
  - start+rd_en together in DONE → rd_valid=0 next cycle and a fill begins.
